// File: rtl/sine_burst_scheduler.sv
// Phase-accumulating sine LUT address sequencer with per-command tuning word,
// sample divider, finite period count and graceful stop at a period boundary.
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   RUN   | emitting samples every div+1 clocks, busy high
module sine_burst_scheduler #(
  parameter int ADDR_WIDTH  = 8,
  parameter int PHASE_WIDTH = 16,
  parameter int CNT_WIDTH   = 16,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [PHASE_WIDTH-1:0] cmd_ftw,
  input  logic [DIV_WIDTH-1:0]   cmd_div,
  input  logic [CNT_WIDTH-1:0]   cmd_cycles,
  input  logic                   stop_req,
  output logic [ADDR_WIDTH-1:0]  lut_addr,
  output logic                   lut_en,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   cycle_cnt,
  output logic                   done,
  output logic                   cmd_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] ftw_q, ftw_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [CNT_WIDTH-1:0]   cycles_q, cycles_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
  logic [ADDR_WIDTH-1:0]  lut_addr_q, lut_addr_d;
  logic                   lut_en_q, lut_en_d;
  logic [CNT_WIDTH-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   stop_pend_q, stop_pend_d;

  logic                   tick;
  logic [PHASE_WIDTH:0]   phase_sum;
  logic [CNT_WIDTH:0]     cnt_inc;
  logic                   last_period;

  assign tick        = (div_cnt_q == div_q);
  assign phase_sum   = {1'b0, phase_q} + {1'b0, ftw_q};
  assign cnt_inc     = {1'b0, cycle_cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign last_period = (cycles_q != '0) && (cnt_inc == {1'b0, cycles_q});

  always_comb begin
    state_d     = state_q;
    ftw_d       = ftw_q;
    div_d       = div_q;
    cycles_d    = cycles_q;
    phase_d     = phase_q;
    div_cnt_d   = div_cnt_q;
    lut_addr_d  = lut_addr_q;
    lut_en_d    = 1'b0;
    cycle_cnt_d = cycle_cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    stop_pend_d = stop_pend_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_ftw == '0) begin
            err_d = 1'b1;
          end else begin
            ftw_d       = cmd_ftw;
            div_d       = cmd_div;
            cycles_d    = cmd_cycles;
            phase_d     = '0;
            div_cnt_d   = '0;
            cycle_cnt_d = '0;
            stop_pend_d = 1'b0;
            state_d     = RUN;
          end
        end
      end
      RUN: begin
        if (stop_req) stop_pend_d = 1'b1;
        if (tick) begin
          div_cnt_d  = '0;
          lut_addr_d = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
          lut_en_d   = 1'b1;
          phase_d    = phase_sum[PHASE_WIDTH-1:0];
          // carry out of the accumulator marks the end of a full period
          if (phase_sum[PHASE_WIDTH]) begin
            cycle_cnt_d = cnt_inc[CNT_WIDTH] ? cycle_cnt_q : cnt_inc[CNT_WIDTH-1:0];
            if (last_period || stop_pend_q || stop_req) begin
              state_d     = IDLE;
              done_d      = 1'b1;
              stop_pend_d = 1'b0;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ftw_q       <= '0;
      div_q       <= '0;
      cycles_q    <= '0;
      phase_q     <= '0;
      div_cnt_q   <= '0;
      lut_addr_q  <= '0;
      lut_en_q    <= 1'b0;
      cycle_cnt_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ftw_q       <= ftw_d;
      div_q       <= div_d;
      cycles_q    <= cycles_d;
      phase_q     <= phase_d;
      div_cnt_q   <= div_cnt_d;
      lut_addr_q  <= lut_addr_d;
      lut_en_q    <= lut_en_d;
      cycle_cnt_q <= cycle_cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign lut_addr  = lut_addr_q;
  assign lut_en    = lut_en_q;
  assign cycle_cnt = cycle_cnt_q;
  assign done      = done_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_sine_burst_scheduler.sv
// Scoreboard bench for sine_burst_scheduler: directed commands push expected
// samples (address, clock edge, done, period count); a negedge monitor pops them.
module tb_sine_burst_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_ftw = '0;
  logic [15:0] cmd_div = '0;
  logic [15:0] cmd_cycles = '0;
  logic        stop_req = 1'b0;
  logic [7:0]  lut_addr;
  logic        lut_en;
  logic        busy;
  logic [15:0] cycle_cnt;
  logic        done;
  logic        cmd_err;

  sine_burst_scheduler dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ftw(cmd_ftw), .cmd_div(cmd_div), .cmd_cycles(cmd_cycles),
    .stop_req(stop_req), .lut_addr(lut_addr), .lut_en(lut_en), .busy(busy),
    .cycle_cnt(cycle_cnt), .done(done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic        dn;
    logic [15:0] cnt;
    int          cyc;
  } smp_t;

  smp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   e_edge = 0;

  logic [7:0] t1_addr [8] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00, 8'h40, 8'h80, 8'hC0};
  logic [7:0] t2_addr [4] = '{8'h00, 8'h40, 8'h80, 8'hC0};
  logic [7:0] t3_addr [3] = '{8'h00, 8'h60, 8'hC0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
               name, act, act, expv, expv, cyc);
    end
  endfunction

  always @(negedge clk) begin
    smp_t e;
    if (rst_n) begin
      if (done) check("done_implies_lut_en", int'(lut_en), 1);
      if (lut_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_sample: got addr 0x%0h expected none at edge %0d",
                   lut_addr, cyc);
        end else begin
          e = exp_q.pop_front();
          check("sample_addr", int'(lut_addr), int'(e.addr));
          check("sample_edge", cyc, e.cyc);
          check("sample_done", int'(done), int'(e.dn));
          if (e.dn) begin
            check("final_cycle_cnt", int'(cycle_cnt), int'(e.cnt));
            check("ready_with_done", int'(cmd_ready), 1);
            check("busy_with_done", int'(busy), 0);
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] a, input logic d, input logic [15:0] c, input int at);
    smp_t s;
    s.addr = a; s.dn = d; s.cnt = c; s.cyc = at;
    exp_q.push_back(s);
  endtask

  // Called between edges; returns #1 after the accepting edge with e_edge set.
  task automatic issue(input logic [15:0] f, input logic [15:0] d, input logic [15:0] c);
    check("ready_before_cmd", int'(cmd_ready), 1);
    cmd_valid  = 1'b1;
    cmd_ftw    = f;
    cmd_div    = d;
    cmd_cycles = c;
    @(posedge clk);
    #1;
    e_edge    = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: got %0d samples pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: got no done expected done within %0d clocks", name, budget);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_lut_en"}, int'(lut_en), 0);
    check({tag, "_lut_addr"}, int'(lut_addr), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_ready"}, int'(cmd_ready), 1);
    check({tag, "_cycle_cnt"}, int'(cycle_cnt), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_cmd_err"}, int'(cmd_err), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // two periods at 4 samples/period, div 0
    issue(16'h4000, 16'd0, 16'd2);
    for (int k = 0; k < 8; k++) push(t1_addr[k], k == 7, 16'd2, e_edge + 1 + k);
    wait_drain("t1", 40);

    // divider 3: one sample every 4 clocks
    @(negedge clk);
    issue(16'h4000, 16'd3, 16'd1);
    for (int k = 0; k < 4; k++) push(t2_addr[k], k == 3, 16'd1, e_edge + 4 + 4 * k);
    wait_drain("t2", 60);

    // non-power-of-two step, then a back-to-back command restarting at 0
    @(negedge clk);
    issue(16'h6000, 16'd0, 16'd1);
    for (int k = 0; k < 3; k++) push(t3_addr[k], k == 2, 16'd1, e_edge + 1 + k);
    wait_done("t3", 20);
    issue(16'h4000, 16'd0, 16'd1);
    for (int k = 0; k < 4; k++) push(t2_addr[k], k == 3, 16'd1, e_edge + 1 + k);
    wait_drain("t3b", 30);

    // continuous mode with a stop request mid-period
    @(negedge clk);
    issue(16'h1000, 16'd0, 16'd0);
    for (int k = 0; k < 16; k++) push(8'(k * 16), k == 15, 16'd1, e_edge + 1 + k);
    repeat (5) @(negedge clk);
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    wait_drain("t4", 60);

    // zero tuning word is rejected
    @(negedge clk);
    issue(16'h0000, 16'd5, 16'd3);
    @(negedge clk);
    check("err_pulse", int'(cmd_err), 1);
    check("err_ready", int'(cmd_ready), 1);
    check("err_busy", int'(busy), 0);
    @(negedge clk);
    check("err_clears", int'(cmd_err), 0);
    check("err_still_idle", int'(busy), 0);

    // reset in the middle of a continuous burst
    @(negedge clk);
    issue(16'h1000, 16'd1, 16'd0);
    for (int k = 0; k < 3; k++) push(8'(k * 16), 1'b0, 16'd0, e_edge + 2 + 2 * k);
    wait_drain("t6", 30);
    @(negedge clk);
    check("pre_abort_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'h4000, 16'd0, 16'd1);
    for (int k = 0; k < 4; k++) push(t2_addr[k], k == 3, 16'd1, e_edge + 1 + k);
    wait_drain("t6b", 30);

    repeat (6) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
